// File: rtl/dmem_sram_pipe_if.sv
// Bus bundle for the dmem_sram_pipe data memory: active-low SRAM controls, address/data, read strobe.
// Optional rd_cnt/wr_cnt lines exist only when DMEM_ACCESS_CNT_EN is defined.
interface dmem_sram_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
);
    logic                  CEN;
    logic                  WEN;
    logic [DATA_W/8-1:0]   BWEN;
    logic                  OEN;
    logic [ADDR_W-1:0]     A;
    logic [DATA_W-1:0]     D;
    logic [DATA_W-1:0]     Q;
    logic                  Q_valid;
    logic                  addr_err;
`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0]           rd_cnt;
    logic [15:0]           wr_cnt;
`endif

    modport master (
        output CEN, WEN, BWEN, OEN, A, D,
        input  Q, Q_valid, addr_err
`ifdef DMEM_ACCESS_CNT_EN
        , input rd_cnt, wr_cnt
`endif
    );

    modport slave (
        input  CEN, WEN, BWEN, OEN, A, D,
        output Q, Q_valid, addr_err
`ifdef DMEM_ACCESS_CNT_EN
        , output rd_cnt, wr_cnt
`endif
    );
endinterface

// File: rtl/dmem_sram_pipe.sv
// Single-port synchronous SRAM data memory with byte write masks, RD_LAT-deep read pipeline,
// held read data and address-range error pulse. Define DMEM_ACCESS_CNT_EN to add rd_cnt/wr_cnt.
module dmem_sram_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    dmem_sram_pipe_if.slave bus
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
        $error("dmem_sram_pipe: DATA_W=%0d must be a non-zero multiple of 8", DATA_W);
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $error("dmem_sram_pipe: DEPTH=%0d outside 1..2**ADDR_W", DEPTH);
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("dmem_sram_pipe: RD_LAT=%0d outside 1..4", RD_LAT);
    end

    // Bytes whose mask bit is low take the new data, the rest keep the stored value.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     bwen_n
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (!bwen_n[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] stg_data_r [RD_LAT];
    logic [RD_LAT-1:0] stg_vld_r;
    logic              addr_err_r;

    logic              in_range_s;
    logic              rd_fire_s;
    logic              wr_fire_s;
    logic [DATA_W-1:0] rd_word_s;

    // Access decode and array read port; out-of-range reads return zero.
    always_comb begin
        in_range_s = ({1'b0, bus.A} < DEPTH_EXT);
        rd_fire_s  = ~bus.CEN & bus.WEN;
        wr_fire_s  = ~bus.CEN & ~bus.WEN;
        rd_word_s  = '0;
        if (in_range_s) begin
            rd_word_s = mem_r[bus.A];
        end else begin
            rd_word_s = '0;
        end
    end

    // Array write port; the array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_fire_s && in_range_s) begin
            mem_r[bus.A] <= byte_merge(mem_r[bus.A], bus.D, bus.BWEN);
        end
    end

    // Read pipeline: a stage only loads when a read arrives, so the last stage holds Q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_vld_r  <= '0;
            addr_err_r <= 1'b0;
            for (int k = 0; k < RD_LAT; k++) begin
                stg_data_r[k] <= '0;
            end
        end else begin
            stg_vld_r[0] <= rd_fire_s;
            if (rd_fire_s) begin
                stg_data_r[0] <= rd_word_s;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                stg_vld_r[k] <= stg_vld_r[k-1];
                if (stg_vld_r[k-1]) begin
                    stg_data_r[k] <= stg_data_r[k-1];
                end
            end
            addr_err_r <= ~bus.CEN & ~in_range_s;
        end
    end

    // Output gate: OEN blanks Q without disturbing the held data.
    always_comb begin
        bus.Q = '0;
        if (bus.OEN) begin
            bus.Q = '0;
        end else begin
            bus.Q = stg_data_r[RD_LAT-1];
        end
    end

    assign bus.Q_valid  = stg_vld_r[RD_LAT-1];
    assign bus.addr_err = addr_err_r;

`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] rd_cnt_r;
    logic [15:0] wr_cnt_r;

    // Saturating access counters; out-of-range and all-masked writes still count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_r <= 16'd0;
            wr_cnt_r <= 16'd0;
        end else begin
            if (rd_fire_s && (rd_cnt_r != 16'hFFFF)) begin
                rd_cnt_r <= rd_cnt_r + 16'd1;
            end
            if (wr_fire_s && (wr_cnt_r != 16'hFFFF)) begin
                wr_cnt_r <= wr_cnt_r + 16'd1;
            end
        end
    end

    assign bus.rd_cnt = rd_cnt_r;
    assign bus.wr_cnt = wr_cnt_r;
`else
    // Access counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_dmem_sram_pipe.sv
// Scoreboard bench for dmem_sram_pipe (RD_LAT=3, DEPTH=100): directed scenarios then random traffic.
module tb_dmem_sram_pipe;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 100;
    localparam int RD_LAT = 3;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_sram_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dmem_sram_pipe #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] mem_m [DEPTH];
    rd_t         exp_q [$];
    logic [31:0] held;
    logic        exp_aerr;
    logic        oen_v;
    logic [15:0] rd_m;
    logic [15:0] wr_m;
    int          edge_cnt;
    int          n_cmp;
    int          n_bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %h expected %h", nm, edge_cnt, act, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, apply the reference model at the posedge.
    task automatic step(input logic cen, input logic wen, input logic [3:0] bwen,
                        input logic [6:0] a, input logic [31:0] d);
        rd_t e;
        @(negedge clk);
        rst      = 1'b0;
        bus.CEN  = cen;
        bus.WEN  = wen;
        bus.BWEN = bwen;
        bus.OEN  = oen_v;
        bus.A    = a;
        bus.D    = d;
        @(posedge clk);
        edge_cnt++;
        exp_aerr = !cen && (int'(a) >= DEPTH);
        if (!cen && wen) begin
            e.data = (int'(a) < DEPTH) ? mem_m[a] : 32'd0;
            e.due  = edge_cnt + RD_LAT - 1;
            exp_q.push_back(e);
            if (rd_m != 16'hFFFF) rd_m++;
        end else if (!cen && !wen) begin
            if (int'(a) < DEPTH) begin
                for (int i = 0; i < 4; i++) begin
                    if (!bwen[i]) mem_m[a][8*i +: 8] = d[8*i +: 8];
                end
            end
            if (wr_m != 16'hFFFF) wr_m++;
        end
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] bwen);
        step(1'b0, 1'b0, bwen, 7'(a), d);
    endtask

    task automatic rd(input int a);
        step(1'b0, 1'b1, 4'hF, 7'(a), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 4'hF, 7'd0, 32'd0);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst      = 1'b1;
        bus.CEN  = 1'b1;
        rd_m     = 16'd0;
        wr_m     = 16'd0;
        exp_aerr = 1'b0;
        @(posedge clk);
        edge_cnt++;
        @(posedge clk);
        edge_cnt++;
    endtask

    // Monitor: compares DUT outputs against the scoreboard just after each falling edge.
    always @(negedge clk) begin
        logic exp_v;
        #1;
        if (rst) begin
            exp_q.delete();
            held = 32'd0;
            chk("rst_q_valid", 32'(bus.Q_valid), 32'd0);
            chk("rst_q", bus.Q, 32'd0);
            chk("rst_addr_err", 32'(bus.addr_err), 32'd0);
        end else begin
            while (exp_q.size() > 0 && exp_q[0].due < edge_cnt) void'(exp_q.pop_front());
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == edge_cnt);
            chk("q_valid", 32'(bus.Q_valid), 32'(exp_v));
            if (exp_v) begin
                held = exp_q[0].data;
                void'(exp_q.pop_front());
            end
            chk("q_data", bus.Q, oen_v ? 32'd0 : held);
            chk("addr_err", 32'(bus.addr_err), 32'(exp_aerr));
        end
`ifdef DMEM_ACCESS_CNT_EN
        chk("rd_cnt", 32'(bus.rd_cnt), rst ? 32'd0 : 32'(rd_m));
        chk("wr_cnt", 32'(bus.wr_cnt), rst ? 32'd0 : 32'(wr_m));
`endif
    end

    initial begin
        int op;
        n_cmp    = 0;
        n_bad    = 0;
        edge_cnt = 0;
        held     = 32'd0;
        exp_aerr = 1'b0;
        oen_v    = 1'b0;
        rd_m     = 16'd0;
        wr_m     = 16'd0;
        rst      = 1'b1;
        bus.CEN  = 1'b1;
        bus.WEN  = 1'b1;
        bus.BWEN = 4'hF;
        bus.OEN  = 1'b0;
        bus.A    = 7'd0;
        bus.D    = 32'd0;

        rst_pulse();
        for (int i = 0; i < DEPTH; i++) wr(i, $urandom, 4'h0);

        // back-to-back reads
        wr(0, 32'h0000000F, 4'h0);
        wr(1, 32'h00000014, 4'h0);
        rd(0);
        rd(1);
        idle(3);

        // byte masks, including a write with every byte masked
        wr(4, 32'hAABBCCDD, 4'b0000);
        wr(4, 32'h11223344, 4'b1010);
        wr(4, 32'h55555555, 4'b1111);
        rd(4);
        idle(3);

        // read-after-write, then OEN blanking of the valid cycle and the held value
        wr(4, 32'd30, 4'h0);
        rd(4);
        idle(2);
        oen_v = 1'b1;
        idle(1);
        oen_v = 1'b0;
        idle(2);

        // pipelined reads followed by hold
        rd(0);
        rd(1);
        rd(4);
        idle(4);

        // out-of-range accesses
        wr(120, 32'hDEADBEEF, 4'h0);
        rd(120);
        rd(20);
        rd(99);
        wr(100, 32'h12345678, 4'h0);
        rd(100);
        idle(4);

        // write while a read of the same word is in flight
        rd(5);
        wr(5, 32'hCAFEF00D, 4'h0);
        rd(5);
        idle(4);

        // reset with two reads in flight; array contents survive
        rd(0);
        rd(1);
        rst_pulse();
        idle(5);
        rd(0);
        idle(4);

        for (int n = 0; n < 800; n++) begin
            op    = int'($urandom_range(0, 3));
            oen_v = ($urandom_range(0, 4) == 0);
            if (op == 0) idle(1);
            else if (op == 1) wr(int'($urandom_range(0, 127)), $urandom, 4'($urandom));
            else rd(int'($urandom_range(0, 127)));
        end

        oen_v = 1'b0;
        idle(RD_LAT + 2);
        chk("drain_pending", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
